// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM requests onto one byte-wide synchronous RAM, splitting 1/2/4-byte accesses.
// Optional macro MEM_CTRL_FAIR_ARB_EN selects round-robin arbitration instead of fixed MEM priority.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_addr,
  input  logic [1:0]  if_rw,
  input  logic [2:0]  if_len,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_rw,
  input  logic [2:0]  mem_len,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  ram_din,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  output logic        busy_out,
  output logic        done_out,
  output logic [1:0]  IF_or_MEM,
  output logic [31:0] data_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  k;
  logic [1:0]  last;
  logic [31:0] base;
  logic [31:0] wdata;
  logic        is_write;
  logic        mem_req;
  logic        if_req;
  logic        grant_mem;
  logic        grant_if;
`ifdef MEM_CTRL_FAIR_ARB_EN
  logic        last_if;
`endif

  // Handshake: a port requests by holding a non-idle rw code; it is granted only in IDLE and must keep the
  // code stable until done_out, then drop it so the following IDLE cycle does not grant it again.
  function automatic logic [1:0] last_index(input logic [2:0] len);
    case (len)
      3'd1:    return 2'd0;
      3'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    mem_req = (mem_rw == 2'b01) || (mem_rw == 2'b10);
    if_req  = (if_rw == 2'b01);
`ifdef MEM_CTRL_FAIR_ARB_EN
    grant_mem = mem_req && (!if_req || last_if);
`else
    grant_mem = mem_req;
`endif
    grant_if = if_req && !grant_mem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= 2'd0;
      last      <= 2'd0;
      base      <= 32'd0;
      wdata     <= 32'd0;
      is_write  <= 1'b0;
      IF_or_MEM <= 2'b00;
      data_out  <= 32'd0;
`ifdef MEM_CTRL_FAIR_ARB_EN
      last_if   <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_mem || grant_if) begin
            state    <= S_ACCESS;
            k        <= 2'd0;
            data_out <= 32'd0;
            if (grant_mem) begin
              base      <= mem_addr;
              last      <= last_index(mem_len);
              is_write  <= (mem_rw == 2'b10);
              wdata     <= mem_wdata;
              IF_or_MEM <= 2'b01;
            end else begin
              base      <= if_addr;
              last      <= last_index(if_len);
              is_write  <= 1'b0;
              wdata     <= 32'd0;
              IF_or_MEM <= 2'b10;
            end
`ifdef MEM_CTRL_FAIR_ARB_EN
            last_if <= grant_if;
`endif
          end
        end
        S_ACCESS: begin
          k <= k + 2'd1;
          // The RAM returns a byte one cycle after its address, so byte k-1 arrives while byte k is addressed.
          if (!is_write && (k != 2'd0)) data_out[{k - 2'd1, 3'b000} +: 8] <= ram_din;
          if (k == last) state <= is_write ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          data_out[{last, 3'b000} +: 8] <= ram_din;
          state <= S_DONE;
        end
        default: begin
          state     <= S_IDLE;
          IF_or_MEM <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    busy_out = (state == S_ACCESS) || (state == S_WAIT);
    done_out = (state == S_DONE);
    ram_wr   = (state == S_ACCESS) && is_write;
    ram_addr = (state == S_ACCESS) ? base + {30'd0, k} : 32'd0;
    ram_dout = ram_wr ? wdata[{k, 3'b000} +: 8] : 8'd0;
  end

endmodule
